// File: rtl/huffman_pkg.sv
// Shared constants and types for the static-table prefix encoder.
package huffman_pkg;

    localparam int unsigned OUT_W        = 16;
    localparam int unsigned MAX_CODE_LEN = 9;
    localparam int unsigned SYM_W        = 8;
    localparam int unsigned LEN_W        = 4;

    // Symbol class boundaries (inclusive upper bounds) and mid-class base
    localparam logic [SYM_W-1:0] CLASS0_MAX  = 8'd3;
    localparam logic [SYM_W-1:0] CLASS1_MAX  = 8'd19;
    localparam logic [3:0]       CLASS1_BASE = 4'd4;

    localparam logic [1:0] PFX_SHORT = 2'b00;
    localparam logic [1:0] PFX_MID   = 2'b01;
    localparam logic       PFX_LONG  = 1'b1;

    localparam logic [LEN_W-1:0] LEN_SHORT = 4'd4;
    localparam logic [LEN_W-1:0] LEN_MID   = 4'd6;
    localparam logic [LEN_W-1:0] LEN_LONG  = 4'd9;

    typedef struct packed {
        logic [MAX_CODE_LEN-1:0] bits;
        logic [LEN_W-1:0]        len;
    } code_t;

endpackage

// File: rtl/huffman_code_lut.sv
// Combinational symbol-to-code table; code is right-aligned in code[8:0].
module huffman_code_lut
    import huffman_pkg::*;
(
    input  logic [SYM_W-1:0]        data_in,
    output logic [MAX_CODE_LEN-1:0] code,
    output logic [LEN_W-1:0]        len
);

    logic [3:0] mid_off;

    // Only the low nibble of (s-4) is kept, so subtract in 4 bits
    assign mid_off = data_in[3:0] - CLASS1_BASE;

    always_comb begin
        code = '0;
        len  = LEN_LONG;
        if (data_in <= CLASS0_MAX) begin
            code = {5'b0, PFX_SHORT, data_in[1:0]};
            len  = LEN_SHORT;
        end else if (data_in <= CLASS1_MAX) begin
            code = {3'b0, PFX_MID, mid_off};
            len  = LEN_MID;
        end else begin
            code = {PFX_LONG, data_in};
            len  = LEN_LONG;
        end
    end

endmodule

// File: rtl/huffman_encoder.sv
// Packs variable-length prefix codes MSB-first into 16-bit words, with a
// flush of the partial word on the falling edge of in_enable.
module huffman_encoder
    import huffman_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_enable,
    input  logic [SYM_W-1:0]  data_in,
    output logic              out_rdy,
    output logic [OUT_W-1:0]  data_out
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned SH_W  = $clog2(ACC_W + 1);

    code_t lut_code;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_hist_q, in_hist_d;
    logic             out_rdy_q, out_rdy_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;

    logic [CNT_W-1:0] new_cnt;
    logic [SH_W-1:0]  shamt;
    logic [ACC_W-1:0] merged;

    huffman_code_lut u_lut (
        .data_in (data_in),
        .code    (lut_code.bits),
        .len     (lut_code.len)
    );

    // Append the new code directly below the bits already held at the MSB
    always_comb begin
        new_cnt = cnt_q + CNT_W'(lut_code.len);
        shamt   = SH_W'(ACC_W) - SH_W'(new_cnt);
        merged  = acc_q | (ACC_W'(lut_code.bits) << shamt);
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        in_hist_d  = in_hist_q;
        out_rdy_d  = 1'b0;
        data_out_d = data_out_q;
        if (enable) begin
            in_hist_d = in_enable;
            if (in_enable) begin
                if (new_cnt >= CNT_W'(OUT_W)) begin
                    data_out_d = merged[ACC_W-1 -: OUT_W];
                    out_rdy_d  = 1'b1;
                    acc_d      = merged << OUT_W;
                    cnt_d      = new_cnt - CNT_W'(OUT_W);
                end else begin
                    acc_d = merged;
                    cnt_d = new_cnt;
                end
            end else if (in_hist_q && (cnt_q != '0)) begin
                // Bits below the count are always zero, giving the pad for free
                data_out_d = acc_q[ACC_W-1 -: OUT_W];
                out_rdy_d  = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            in_hist_q  <= 1'b0;
            out_rdy_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            in_hist_q  <= in_hist_d;
            out_rdy_q  <= out_rdy_d;
            data_out_q <= data_out_d;
        end
    end

    assign out_rdy  = out_rdy_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed self-checking bench for huffman_encoder.
module tb_huffman_encoder;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        in_enable;
    logic [7:0]  data_in;
    logic        out_rdy;
    logic [15:0] data_out;

    int vectors     = 0;
    int miscompares = 0;

    bit bits_q[$];
    int model_cnt;

    huffman_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_enable (in_enable),
        .data_in   (data_in),
        .out_rdy   (out_rdy),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] sym);
        enable    = 1'b1;
        in_enable = 1'b1;
        data_in   = sym;
        tick();
    endtask

    task automatic idle();
        enable    = 1'b1;
        in_enable = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        enable    = 1'b0;
        in_enable = 1'b0;
        #3;
        chk("rst_rdy", 32'(out_rdy), 32'd0);
        chk("rst_data", 32'(data_out), 32'h0);
        tick();
        rst = 1'b1;
    endtask

    // Reference table straight from the code definition
    function automatic void model_push(input logic [7:0] s);
        logic [8:0] c;
        int         l;
        logic [7:0] d;
        if (s < 8'd4) begin
            c = {7'b0, s[1:0]};
            l = 4;
        end else if (s < 8'd20) begin
            d = s - 8'd4;
            c = {3'b0, 2'b01, d[3:0]};
            l = 6;
        end else begin
            c = {1'b1, s};
            l = 9;
        end
        for (int i = l - 1; i >= 0; i--) bits_q.push_back(c[i]);
        model_cnt += l;
    endfunction

    function automatic logic [15:0] model_pop_word();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {w[14:0], (bits_q.size() > 0) ? bits_q.pop_front() : 1'b0};
        end
        return w;
    endfunction

    logic [7:0]  stream [8];
    logic [15:0] exp_w;
    int          words;

    initial begin
        rst       = 1'b0;
        enable    = 1'b0;
        in_enable = 1'b0;
        data_in   = 8'h00;
        #2;
        do_reset();

        // Idle with enable low and random inputs
        for (int i = 0; i < 5; i++) begin
            enable    = 1'b0;
            in_enable = 1'($urandom_range(0, 1));
            data_in   = 8'($urandom_range(0, 255));
            tick();
            chk("idle_rdy", 32'(out_rdy), 32'd0);
            chk("idle_data", 32'(data_out), 32'h0);
        end

        // Exactly one word from four short codes
        send(8'd0); chk("fill_rdy0", 32'(out_rdy), 32'd0);
        send(8'd1); chk("fill_rdy1", 32'(out_rdy), 32'd0);
        send(8'd2); chk("fill_rdy2", 32'(out_rdy), 32'd0);
        send(8'd3);
        chk("fill_rdy3", 32'(out_rdy), 32'd1);
        chk("fill_data", 32'(data_out), 32'h0123);
        idle(); chk("fill_noflush", 32'(out_rdy), 32'd0);
        idle(); chk("fill_noflush2", 32'(out_rdy), 32'd0);
        chk("fill_hold", 32'(data_out), 32'h0123);

        // Codes straddling word boundaries
        send(8'd5);  chk("str_rdy5", 32'(out_rdy), 32'd0);
        send(8'd68); chk("str_rdy68", 32'(out_rdy), 32'd0);
        send(8'd50);
        chk("str_rdy50", 32'(out_rdy), 32'd1);
        chk("str_data50", 32'(data_out), 32'h4689);
        send(8'd100);
        chk("str_rdy100", 32'(out_rdy), 32'd1);
        chk("str_data100", 32'(data_out), 32'h32B2);
        idle();
        chk("str_flush_rdy", 32'(out_rdy), 32'd1);
        chk("str_flush_data", 32'(data_out), 32'h0000);
        idle(); chk("str_after", 32'(out_rdy), 32'd0);

        // Single-symbol flush
        do_reset();
        send(8'd5); chk("fl_rdy_s", 32'(out_rdy), 32'd0);
        idle();
        chk("fl_rdy", 32'(out_rdy), 32'd1);
        chk("fl_data", 32'(data_out), 32'h4400);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("fl_quiet", 32'(out_rdy), 32'd0);
            chk("fl_hold", 32'(data_out), 32'h4400);
        end

        // Reset mid-stream drops buffered bits without a flush
        send(8'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(out_rdy), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'h0);
        tick();
        rst = 1'b1;
        idle(); chk("mid_rst_noflush", 32'(out_rdy), 32'd0);
        idle(); chk("mid_rst_noflush2", 32'(out_rdy), 32'd0);

        // Enable gating freezes everything
        send(8'd5);
        send(8'd68);
        for (int i = 0; i < 10; i++) begin
            enable    = 1'b0;
            in_enable = 1'(i % 2);
            data_in   = 8'(i * 37 + 11);
            tick();
            chk("gate_rdy", 32'(out_rdy), 32'd0);
        end
        send(8'd50);
        chk("gate_rdy50", 32'(out_rdy), 32'd1);
        chk("gate_data50", 32'(data_out), 32'h4689);
        idle();
        chk("gate_flush_rdy", 32'(out_rdy), 32'd1);
        chk("gate_flush_data", 32'(data_out), 32'h3200);

        // Flush pending across enable low is taken once enable returns
        send(8'd5);
        for (int i = 0; i < 3; i++) begin
            enable    = 1'b0;
            in_enable = 1'b0;
            tick();
            chk("pend_rdy", 32'(out_rdy), 32'd0);
        end
        idle();
        chk("pend_flush_rdy", 32'(out_rdy), 32'd1);
        chk("pend_flush_data", 32'(data_out), 32'h4400);

        // Sustained stream against the software packer
        do_reset();
        stream[0] = 8'd5;   stream[1] = 8'd68;  stream[2] = 8'd50;  stream[3] = 8'd100;
        stream[4] = 8'd150; stream[5] = 8'd200; stream[6] = 8'd250; stream[7] = 8'd255;
        bits_q.delete();
        model_cnt = 0;
        words     = 0;
        for (int i = 0; i < 8; i++) begin
            model_push(stream[i]);
            send(stream[i]);
            if (model_cnt >= 16) begin
                model_cnt -= 16;
                exp_w = model_pop_word();
                words++;
                chk("sus_rdy", 32'(out_rdy), 32'd1);
                chk("sus_data", 32'(data_out), 32'(exp_w));
            end else begin
                chk("sus_rdy", 32'(out_rdy), 32'd0);
            end
        end
        idle();
        if (model_cnt > 0) begin
            exp_w = model_pop_word();
            words++;
            chk("sus_flush_rdy", 32'(out_rdy), 32'd1);
            chk("sus_flush_data", 32'(data_out), 32'(exp_w));
        end else begin
            chk("sus_flush_rdy", 32'(out_rdy), 32'd0);
        end
        chk("sus_words", 32'(words), 32'd5);
        idle(); chk("sus_quiet", 32'(out_rdy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
